// File: rtl/des_dec_key_sched_if.sv
// Bus between the DES decryption key scheduler and its two neighbours:
// the key loader (key_*) and the round-key consumer (rk_*).
interface des_dec_key_sched_if;
  logic [55:0] key_i;
  logic        key_valid_i;
  logic        key_ready_o;
  logic        abort_i;
  logic [47:0] rk_o;
  logic [3:0]  rk_idx_o;
  logic        rk_last_o;
  logic        rk_valid_o;
  logic        rk_ready_i;

  modport slave (
    input  key_i, key_valid_i, abort_i, rk_ready_i,
    output key_ready_o, rk_o, rk_idx_o, rk_last_o, rk_valid_o
  );

  modport master (
    output key_i, key_valid_i, abort_i, rk_ready_i,
    input  key_ready_o, rk_o, rk_idx_o, rk_last_o, rk_valid_o
  );
endinterface

// File: rtl/des_dec_key_sched.sv
// Iterative DES decryption key scheduler: takes C0||D0 and hands out K16..K1,
// one round key per rk_valid_o/rk_ready_i handshake.
module des_dec_key_sched #(
  parameter int unsigned OUT_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  des_dec_key_sched_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  r_q, r_d;
  logic [47:0] rk_q, rk_d;
  logic [3:0]  idx_q, idx_d;
  logic        last_q, last_d;

  logic [55:0] cd_rot;
  logic        single_shift;
  logic        in_run;
  logic        rk_fire;

  // PC-2: output bit 1 (MSB) first; each entry is the source bit position in cd[55:0].
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    pc2 = {cd[42], cd[39], cd[45], cd[32], cd[55], cd[51],
           cd[53], cd[28], cd[41], cd[50], cd[35], cd[46],
           cd[33], cd[37], cd[44], cd[52], cd[30], cd[48],
           cd[40], cd[49], cd[29], cd[36], cd[43], cd[54],
           cd[15], cd[4],  cd[25], cd[19], cd[9],  cd[1],
           cd[26], cd[16], cd[5],  cd[11], cd[23], cd[8],
           cd[12], cd[7],  cd[17], cd[0],  cd[22], cd[3],
           cd[10], cd[14], cd[6],  cd[20], cd[27], cd[24]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic by_one);
    rotr = by_one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  assign in_run  = (state_q == ST_RUN);
  assign rk_fire = in_run && bus.rk_ready_i;

  // Undoing encryption shifts 16, 9 and 2 (the single-bit ones) happens at r = 0, 7, 14.
  assign single_shift = (r_q == 4'd0) || (r_q == 4'd7) || (r_q == 4'd14);
  assign cd_rot = {rotr(cd_q[55:28], single_shift), rotr(cd_q[27:0], single_shift)};

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    r_d     = r_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.key_valid_i) begin
          cd_d    = bus.key_i;
          r_d     = 4'd0;
          state_d = (OUT_REG != 0) ? ST_LOAD : ST_RUN;
        end
      end
      ST_LOAD: begin
        rk_d    = pc2(cd_q);
        idx_d   = 4'd15;
        last_d  = 1'b0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (rk_fire) begin
          if (r_q == 4'd15) begin
            state_d = ST_IDLE;
          end else begin
            r_d    = r_q + 4'd1;
            cd_d   = cd_rot;
            rk_d   = pc2(cd_rot);
            idx_d  = 4'd14 - r_q;
            last_d = (r_q == 4'd14);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cd_q    <= '0;
      r_q     <= '0;
      rk_q    <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      r_q     <= r_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  // Unregistered variant gates the outputs to zero outside RUN so they read 0 after reset.
  assign bus.key_ready_o = (state_q == ST_IDLE);
  assign bus.rk_valid_o  = in_run;
  assign bus.rk_o        = (OUT_REG != 0) ? rk_q   : (in_run ? pc2(cd_q) : 48'd0);
  assign bus.rk_idx_o    = (OUT_REG != 0) ? idx_q  : (in_run ? (4'd15 - r_q) : 4'd0);
  assign bus.rk_last_o   = (OUT_REG != 0) ? last_q : (in_run && (r_q == 4'd15));

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Runs the unregistered (dut0) and registered (dut1) schedulers side by side against
// a reference that derives each round key from the forward DES left-shift schedule.
module tb_des_dec_key_sched;

  localparam logic [55:0] TEST_KEY = 56'hF0CCAAF556678F;
  localparam logic [47:0] K16_REF  = 48'hCB3D8B0E17F5;
  localparam logic [47:0] K1_REF   = 48'h1B02EFFC7072;

  logic        clk;
  logic        rstIn;
  logic [55:0] keyIn;
  logic        kv;
  logic        abortIn;
  logic        rdyIn;

  int cmpCount = 0;
  int errCount = 0;

  des_dec_key_sched_if bus0 ();
  des_dec_key_sched_if bus1 ();

  assign bus0.key_i       = keyIn;
  assign bus0.key_valid_i = kv;
  assign bus0.abort_i     = abortIn;
  assign bus0.rk_ready_i  = rdyIn;
  assign bus1.key_i       = keyIn;
  assign bus1.key_valid_i = kv;
  assign bus1.abort_i     = abortIn;
  assign bus1.rk_ready_i  = rdyIn;

  des_dec_key_sched #(.OUT_REG(0)) dut0 (.clk(clk), .rst(rstIn), .bus(bus0));
  des_dec_key_sched #(.OUT_REG(1)) dut1 (.clk(clk), .rst(rstIn), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Standard 1-based PC-2 table (bit 1 = MSB of C||D).
  int pc2Tab [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Encryption round key K_n: C/D rotated left by the forward shift schedule, then PC-2.
  function automatic logic [47:0] refKey(input logic [55:0] k, input int n);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] out;
    int sh;
    c = k[55:28];
    d = k[27:0];
    for (int i = 1; i <= n; i++) begin
      sh = (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
      for (int s = 0; s < sh; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
    end
    cd = {c, d};
    out = '0;
    for (int j = 0; j < 48; j++) out[47 - j] = cd[56 - pc2Tab[j]];
    return out;
  endfunction

  // Transaction-level model per instance: 0 = idle, 1 = load, 2 = delivering keys.
  int          mState [2] = '{0, 0};
  int          mPos   [2] = '{0, 0};
  logic [55:0] mKey   [2];
  bit          mFresh [2] = '{1, 1};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rstIn) begin
        mState[i] <= 0;
        mPos[i]   <= 0;
        mFresh[i] <= 1'b1;
      end else begin
        case (mState[i])
          0: if (kv) begin
            mKey[i]   <= keyIn;
            mPos[i]   <= 0;
            mFresh[i] <= 1'b0;
            mState[i] <= (i == 1) ? 1 : 2;
          end
          1: mState[i] <= abortIn ? 0 : 2;
          2: begin
            if (abortIn) mState[i] <= 0;
            else if (rdyIn) begin
              if (mPos[i] == 15) mState[i] <= 0;
              else mPos[i] <= mPos[i] + 1;
            end
          end
          default: mState[i] <= 0;
        endcase
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    cmpCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic checkAll();
    logic        ready, valid, last;
    logic [47:0] rk;
    logic [3:0]  idx;
    for (int i = 0; i < 2; i++) begin
      ready = (i == 0) ? bus0.key_ready_o : bus1.key_ready_o;
      valid = (i == 0) ? bus0.rk_valid_o  : bus1.rk_valid_o;
      last  = (i == 0) ? bus0.rk_last_o   : bus1.rk_last_o;
      rk    = (i == 0) ? bus0.rk_o        : bus1.rk_o;
      idx   = (i == 0) ? bus0.rk_idx_o    : bus1.rk_idx_o;
      checkOutput($sformatf("keyReady%0d", i), 64'(ready), 64'(mState[i] == 0));
      checkOutput($sformatf("rkValid%0d", i), 64'(valid), 64'(mState[i] == 2));
      if (mState[i] == 2) begin
        checkOutput($sformatf("rk%0d", i), 64'(rk), 64'(refKey(mKey[i], 16 - mPos[i])));
        checkOutput($sformatf("rkIdx%0d", i), 64'(idx), 64'(15 - mPos[i]));
        checkOutput($sformatf("rkLast%0d", i), 64'(last), 64'(mPos[i] == 15));
      end else if (mState[i] == 0 && mFresh[i]) begin
        checkOutput($sformatf("rstRk%0d", i), 64'(rk), 64'd0);
        checkOutput($sformatf("rstIdx%0d", i), 64'(idx), 64'd0);
        checkOutput($sformatf("rstLast%0d", i), 64'(last), 64'd0);
      end
    end
  endtask

  task automatic applyStimulus(input bit kvV, input logic [55:0] keyV, input bit abortV,
                               input bit rdyV, input bit rstV);
    kv      = kvV;
    keyIn   = keyV;
    abortIn = abortV;
    rdyIn   = rdyV;
    rstIn   = rstV;
    @(posedge clk);
    #1;
    checkAll();
  endtask

  // One schedule from idle; optional stray key pulse, abort or reset at a given cycle.
  task automatic runSchedule(input logic [55:0] k, input bit randRdy, input bit anchors,
                             input int pulseCyc, input int abortCyc, input int rstCyc);
    int  lat [2];
    bit  done;
    bit  valid, last;
    logic [47:0] rk;
    logic [55:0] keyNow;
    lat  = '{0, 0};
    done = 1'b0;
    for (int c = 1; c <= 200 && !done; c++) begin
      keyNow = (c == pulseCyc) ? 56'd0 : k;
      applyStimulus((c == 1) || (c == pulseCyc), keyNow, (c == abortCyc),
                    randRdy ? 1'($urandom_range(0, 1)) : 1'b1, (c == rstCyc));
      for (int i = 0; i < 2; i++) begin
        valid = (i == 0) ? bus0.rk_valid_o : bus1.rk_valid_o;
        last  = (i == 0) ? bus0.rk_last_o  : bus1.rk_last_o;
        rk    = (i == 0) ? bus0.rk_o       : bus1.rk_o;
        if (valid && lat[i] == 0) begin
          lat[i] = c;
          if (anchors) checkOutput($sformatf("firstKey%0d", i), 64'(rk), 64'(K16_REF));
        end
        if (anchors && valid && last)
          checkOutput($sformatf("lastKey%0d", i), 64'(rk), 64'(K1_REF));
      end
      if (c > 1 && bus0.key_ready_o && bus1.key_ready_o) done = 1'b1;
    end
    if (!done) checkOutput("scheduleTimeout", 64'd0, 64'd1);
    checkOutput("latency0", 64'(lat[0]), 64'd1);
    checkOutput("latency1", 64'(lat[1]), 64'd2);
    applyStimulus(1'b0, k, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [55:0] rndKey;
    applyStimulus(1'b0, 56'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 56'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 56'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] known-answer schedule, continuous ready");
    runSchedule(TEST_KEY, 1'b0, 1'b1, 0, 0, 0);
    $display("[TB] known-answer schedule, random stalls");
    runSchedule(TEST_KEY, 1'b1, 1'b1, 0, 0, 0);
    $display("[TB] stray zero key during RUN, then zero key");
    runSchedule(TEST_KEY, 1'b1, 1'b1, 5, 0, 0);
    runSchedule(56'd0, 1'b1, 1'b0, 0, 0, 0);
    $display("[TB] abort mid-schedule, then reload");
    runSchedule(TEST_KEY, 1'b0, 1'b1, 0, 7, 0);
    runSchedule(TEST_KEY, 1'b0, 1'b1, 0, 0, 0);
    $display("[TB] reset mid-schedule, then reload");
    runSchedule(TEST_KEY, 1'b1, 1'b1, 0, 0, 9);
    runSchedule(TEST_KEY, 1'b1, 1'b1, 0, 0, 0);
    $display("[TB] random keys");
    for (int n = 0; n < 6; n++) begin
      rndKey = {24'($urandom), $urandom};
      runSchedule(rndKey, 1'b1, 1'b0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/des_dec_key_sched.md
Name: des_dec_key_sched

Overview:
Iterative DES decryption key scheduler. It accepts one 56-bit post-PC-1 key (C0||D0) and emits the 16 round keys in decryption order (K16 first, K1 last), one per handshake.
C/D state is rotated right between keys, which is the mirror of the encryption-side left-shift schedule. PC-2 compression reuses the existing p_box_56_48.
It sits ahead of the iterative DES decrypt datapath, which pulls keys with a valid/ready handshake.

Parameters:
OUT_REG, 1, 1 = round-key outputs registered (one extra cycle from accept to first key); 0 = combinational PC-2 off the C/D register.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
key_i  input  56  C0||D0 (C = [55:28], D = [27:0])
key_valid_i  input  1  key_i valid
key_ready_o  output  1  scheduler idle, can accept a key
abort_i  input  1  drop current schedule, return to IDLE
rk_o  output  48  current round key (PC-2 of C/D)
rk_idx_o  output  4  encryption index of rk_o minus 1 (15 = K16 ... 0 = K1)
rk_last_o  output  1  rk_o is K1 (final key)
rk_valid_o  output  1  rk_o valid
rk_ready_i  input  1  consumer takes rk_o

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high. On reset the FSM goes to IDLE, and C/D, count, rk_o, rk_idx_o, rk_last_o and rk_valid_o are all cleared to 0. key_ready_o is 1 from the first cycle after reset.
- State: 56-bit C/D register; 4-bit count r (0..15 = decryption round minus 1); FSM {IDLE, LOAD, RUN}.
- IDLE: key_ready_o = 1, rk_valid_o = 0.
  - key_valid_i & key_ready_o: C/D <= key_i, r <= 0.
  - Next state is LOAD if OUT_REG = 1, else RUN.
- LOAD (OUT_REG = 1 only): output register <= PC-2(C/D), idx 15; go to RUN. Lasts one cycle; key_ready_o = 0.
- RUN: rk_valid_o = 1, key_ready_o = 0.
  - rk_o = PC-2(C/D), rk_idx_o = 15 - r, rk_last_o = (r == 15).
  - All outputs hold stable while rk_ready_i = 0.
- Handshake in RUN (rk_valid_o & rk_ready_i):
  - If r == 15: go to IDLE, rk_valid_o = 0 next cycle.
  - Otherwise: r <= r + 1, and C and D are each rotated right independently by 1 if r is in {0, 7, 14}, else by 2.
  - With OUT_REG = 1, the output register loads PC-2 of the rotated value in the same edge. Back-to-back keys at 1 per cycle are required under continuous rk_ready_i.
- Rotate right by 1: {x[0], x[27:1]}. Rotate right by 2: {x[1:0], x[27:2]}.
- Latency from key accept to first rk_valid_o: 1 cycle if OUT_REG = 0, 2 cycles if OUT_REG = 1. A full schedule takes 16 handshakes, no idle cycles between keys.
- After the 16th handshake C/D holds C1||D1 (27 net right rotations). Its contents are don't-care afterwards.
- key_valid_i while not IDLE is ignored; the key is not latched.
- abort_i outranks the handshake: in LOAD or RUN it forces IDLE next cycle and clears rk_valid_o. In IDLE it has no effect.
- rst asserted mid-schedule: IDLE next cycle, all outputs at reset values, and the in-flight key is discarded.

Test Plan:
- Load key_i = 0xF0CCAAF556678F (from DES key 0x133457799BBCDFF1), rk_ready_i = 1. Required: rk_o sequence 0xCB3D8B0E17F5, 0xBF918D3D3F0A, 0x5F43B7F2E73A, ..., 0x79AED9DBC9E5, 0x1B02EFFC7072 on 16 consecutive cycles. rk_idx_o counts 15..0 and rk_last_o is high only with 0x1B02EFFC7072.
- Same key, rk_ready_i toggled 1-0-0-1 randomly. Required: rk_o, rk_idx_o and rk_last_o stable during stalls; all 16 keys delivered exactly once, in order.
- key_valid_i pulsed with a second key (0x00000000000000) during RUN. Required: ignored, key_ready_o = 0, first key's sequence unchanged. After the last key, the new key is accepted and rk_o = 0x000000000000 for all 16 keys.
- abort_i asserted after the 5th handshake. Required: rk_valid_o = 0 and key_ready_o = 1 next cycle. A reload then restarts at 0xCB3D8B0E17F5 with idx 15.
- rst asserted for one cycle in mid-RUN. Required: all outputs 0 except key_ready_o = 1, and the next schedule is correct from K16.
- Repeat the first scenario with OUT_REG = 0 and OUT_REG = 1. Required: identical key sequences; first rk_valid_o arrives 1 and 2 cycles after accept, respectively.
